// File: rtl/matmul_pkg.sv
// Shared constants, accumulator sizing and FSM state type for the matrix multiplier.
package matmul_pkg;

  localparam int DW_DEF = 8;
  localparam int M_DEF  = 8;
  localparam int N_DEF  = 8;
  localparam int P_DEF  = 8;

  // Wide enough to hold a sum of n signed dw x dw products without overflow.
  function automatic int ACC_W(input int dw, input int n);
    return 2 * dw + $clog2(n) + 1;
  endfunction

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_COMPUTE,
    S_DONE
  } state_t;

endpackage

// File: rtl/systolic_pe.sv
// One processing element of the systolic grid: signed MAC that forwards its
// operands one hop right (a) and one hop down (b) per enabled cycle.
module systolic_pe
  import matmul_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = ACC_W(DW_DEF, N_DEF)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 en,
  input  logic signed [DW-1:0] a_in,
  input  logic signed [DW-1:0] b_in,
  output logic signed [DW-1:0] a_out,
  output logic signed [DW-1:0] b_out,
  output logic signed [AW-1:0] acc
);

  logic signed [2*DW-1:0] w_prod;

  assign w_prod = a_in * b_in;

  // Accumulate the product and pass operands on to the neighbouring PEs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_out <= '0;
      b_out <= '0;
      acc   <= '0;
    end else if (clear) begin
      a_out <= '0;
      b_out <= '0;
      acc   <= '0;
    end else if (en) begin
      a_out <= a_in;
      b_out <= b_in;
      acc   <= acc + {{(AW-2*DW){w_prod[2*DW-1]}}, w_prod};
    end
  end

endmodule

// File: rtl/matrix_multiplier.sv
// Output-stationary systolic matrix multiplier, C = A x B, result truncated
// to DATA_WIDTH bits per element.
//
//   state     | meaning
//   ----------+----------------------------------------------------------
//   S_IDLE    | nothing computed since reset; waiting for start
//   S_LOAD    | operands captured; clear accumulators, skew regs, counter
//   S_COMPUTE | skewed operands stream through the PE grid
//   S_DONE    | result_c valid and frozen; start launches a new multiply
module matrix_multiplier
  import matmul_pkg::*;
#(
  parameter int DATA_WIDTH = DW_DEF,
  parameter int M          = M_DEF,
  parameter int N          = N_DEF,
  parameter int P          = P_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [M*N*DATA_WIDTH-1:0]    matrix_a,
  input  logic [N*P*DATA_WIDTH-1:0]    matrix_b,
  output logic                         done,
  output logic [M*P*DATA_WIDTH-1:0]    result_c
);

  localparam int DW = DATA_WIDTH;
  localparam int AW = ACC_W(DW, N);
  localparam int CW = $clog2(M + N + P);
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  // Last compute cycle: PE(M-1,P-1) consumes k=N-1 at count M+N+P-3, and
  // one more cycle lets that accumulation land before result_c samples it.
  localparam logic [CW-1:0] CNT_LAST = CW'(M + N + P - 2);
  localparam logic [CW-1:0] K_END    = CW'(N);

  state_t                  r_state;
  logic [CW-1:0]           r_cnt;
  logic                    r_done;
  logic [M*P*DW-1:0]       r_result;
  logic signed [DW-1:0]    r_a [M][N];
  logic signed [DW-1:0]    r_b [N][P];

  logic                    w_compute;
  logic                    w_load;
  logic signed [DW-1:0]    w_a_feed [M];
  logic signed [DW-1:0]    w_b_feed [P];
  logic signed [DW-1:0]    w_a_skew [M];
  logic signed [DW-1:0]    w_b_skew [P];
  logic signed [DW-1:0]    w_a_out  [M][P];
  logic signed [DW-1:0]    w_b_out  [M][P];
  logic signed [AW-1:0]    w_acc    [M][P];
  logic                    w_unused;

  assign w_compute = (r_state == S_COMPUTE);
  assign w_load    = (r_state == S_LOAD);
  assign done      = r_done;
  assign result_c  = r_result;

  // Column k of A and row k of B are presented at count k; zeros afterwards.
  always_comb begin
    for (int i = 0; i < M; i++) w_a_feed[i] = '0;
    for (int j = 0; j < P; j++) w_b_feed[j] = '0;
    if (w_compute && (r_cnt < K_END)) begin
      for (int i = 0; i < M; i++) w_a_feed[i] = r_a[i][r_cnt[KW-1:0]];
      for (int j = 0; j < P; j++) w_b_feed[j] = r_b[r_cnt[KW-1:0]][j];
    end
  end

  // Sequencer: operand capture, compute count and registered result/done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_done   <= 1'b0;
      r_result <= '0;
      for (int i = 0; i < M; i++)
        for (int k = 0; k < N; k++) r_a[i][k] <= '0;
      for (int k = 0; k < N; k++)
        for (int j = 0; j < P; j++) r_b[k][j] <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            for (int i = 0; i < M; i++)
              for (int k = 0; k < N; k++) r_a[i][k] <= matrix_a[(i*N+k)*DW +: DW];
            for (int k = 0; k < N; k++)
              for (int j = 0; j < P; j++) r_b[k][j] <= matrix_b[(k*P+j)*DW +: DW];
            r_done  <= 1'b0;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_cnt   <= '0;
          r_state <= S_COMPUTE;
        end
        S_COMPUTE: begin
          if (r_cnt == CNT_LAST) begin
            for (int i = 0; i < M; i++)
              for (int j = 0; j < P; j++) r_result[(i*P+j)*DW +: DW] <= w_acc[i][j][DW-1:0];
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Row i of A is delayed i cycles before entering PE column 0.
  for (genvar gi = 0; gi < M; gi++) begin : g_askew
    if (gi == 0) begin : g_direct
      assign w_a_skew[gi] = w_a_feed[gi];
    end else begin : g_chain
      logic signed [DW-1:0] r_chain [gi];
      // Delay line, flushed at LOAD so a new run starts from zeros.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int s = 0; s < gi; s++) r_chain[s] <= '0;
        end else if (w_load) begin
          for (int s = 0; s < gi; s++) r_chain[s] <= '0;
        end else if (w_compute) begin
          r_chain[0] <= w_a_feed[gi];
          for (int s = 1; s < gi; s++) r_chain[s] <= r_chain[s-1];
        end
      end
      assign w_a_skew[gi] = r_chain[gi-1];
    end
  end

  // Column j of B is delayed j cycles before entering PE row 0.
  for (genvar gj = 0; gj < P; gj++) begin : g_bskew
    if (gj == 0) begin : g_direct
      assign w_b_skew[gj] = w_b_feed[gj];
    end else begin : g_chain
      logic signed [DW-1:0] r_chain [gj];
      // Delay line, flushed at LOAD so a new run starts from zeros.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int s = 0; s < gj; s++) r_chain[s] <= '0;
        end else if (w_load) begin
          for (int s = 0; s < gj; s++) r_chain[s] <= '0;
        end else if (w_compute) begin
          r_chain[0] <= w_b_feed[gj];
          for (int s = 1; s < gj; s++) r_chain[s] <= r_chain[s-1];
        end
      end
      assign w_b_skew[gj] = r_chain[gj-1];
    end
  end

  for (genvar gi = 0; gi < M; gi++) begin : g_row
    for (genvar gj = 0; gj < P; gj++) begin : g_col
      logic signed [DW-1:0] w_pe_a;
      logic signed [DW-1:0] w_pe_b;
      if (gj == 0) begin : g_a_edge
        assign w_pe_a = w_a_skew[gi];
      end else begin : g_a_link
        assign w_pe_a = w_a_out[gi][gj-1];
      end
      if (gi == 0) begin : g_b_edge
        assign w_pe_b = w_b_skew[gj];
      end else begin : g_b_link
        assign w_pe_b = w_b_out[gi-1][gj];
      end
      systolic_pe #(.DW(DW), .AW(AW)) u_pe (
        .clk   (clk),
        .rst   (rst),
        .clear (w_load),
        .en    (w_compute),
        .a_in  (w_pe_a),
        .b_in  (w_pe_b),
        .a_out (w_a_out[gi][gj]),
        .b_out (w_b_out[gi][gj]),
        .acc   (w_acc[gi][gj])
      );
    end
  end

  // Grid-edge forwards and accumulator bits above DW have no consumer.
  always_comb begin
    w_unused = 1'b0;
    for (int i = 0; i < M; i++) w_unused = w_unused ^ (^w_a_out[i][P-1]);
    for (int j = 0; j < P; j++) w_unused = w_unused ^ (^w_b_out[M-1][j]);
    for (int i = 0; i < M; i++)
      for (int j = 0; j < P; j++) w_unused = w_unused ^ (^w_acc[i][j][AW-1:DW]);
  end

endmodule

// File: tb/tb_matrix_multiplier.sv
// Self-checking bench for matrix_multiplier: directed and random operands
// compared against a plain nested-loop matrix product.
module tb_matrix_multiplier;

  localparam int DW   = 8;
  localparam int M    = 8;
  localparam int N    = 8;
  localparam int P    = 8;
  localparam int AWID = M * N * DW;
  localparam int BWID = N * P * DW;
  localparam int CWID = M * P * DW;
  localparam int LAT  = M + N + P;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [AWID-1:0] matrix_a;
  logic [BWID-1:0] matrix_b;
  logic            done;
  logic [CWID-1:0] result_c;

  int n_checks = 0;
  int n_fail   = 0;

  matrix_multiplier #(.DATA_WIDTH(DW), .M(M), .N(N), .P(P)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .matrix_a (matrix_a),
    .matrix_b (matrix_b),
    .done     (done),
    .result_c (result_c)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CWID-1:0] ref_mm(input logic [AWID-1:0] a, input logic [BWID-1:0] b);
    logic [CWID-1:0] c;
    int  sum;
    byte av, bv;
    c = '0;
    for (int i = 0; i < M; i++)
      for (int j = 0; j < P; j++) begin
        sum = 0;
        for (int k = 0; k < N; k++) begin
          av  = a[(i*N+k)*DW +: DW];
          bv  = b[(k*P+j)*DW +: DW];
          sum = sum + av * bv;
        end
        c[(i*P+j)*DW +: DW] = sum[DW-1:0];
      end
    return c;
  endfunction

  function automatic logic [AWID-1:0] rnd_a();
    logic [AWID-1:0] v;
    for (int w = 0; w < AWID / 32; w++) v[w*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [BWID-1:0] rnd_b();
    logic [BWID-1:0] v;
    for (int w = 0; w < BWID / 32; w++) v[w*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic check_c(input string tag, input logic [CWID-1:0] exp);
    for (int e = 0; e < M * P; e++)
      chk_eq($sformatf("%s_c%0d", tag, e), 64'(result_c[e*DW +: DW]), 64'(exp[e*DW +: DW]));
  endtask

  // Start edge is cycle 0; operands are scrambled right after capture.
  task automatic launch(input string tag, input logic [AWID-1:0] a, input logic [BWID-1:0] b);
    @(negedge clk);
    matrix_a = a;
    matrix_b = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    matrix_a = rnd_a();
    matrix_b = rnd_b();
    chk_eq({tag, "_done_clr"}, 64'(done), 64'(0));
  endtask

  task automatic wait_done(input string tag, input int from);
    int lat;
    lat = from;
    while (lat < 3 * LAT) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) break;
    end
    chk_eq({tag, "_latency"}, 64'(lat), 64'(LAT));
  endtask

  task automatic run_mm(input string tag, input logic [AWID-1:0] a, input logic [BWID-1:0] b);
    logic [CWID-1:0] exp;
    exp = ref_mm(a, b);
    launch(tag, a, b);
    wait_done(tag, 0);
    check_c(tag, exp);
  endtask

  logic [AWID-1:0] ta;
  logic [BWID-1:0] tb;
  logic [CWID-1:0] tc;

  initial begin
    rst      = 1'b0;
    start    = 1'b0;
    matrix_a = '0;
    matrix_b = '0;
    #12;
    chk_eq("reset_done", 64'(done), 64'(0));
    chk_eq("reset_result", 64'(|result_c), 64'(0));
    @(negedge clk);
    rst = 1'b1;

    // 1: ramp pattern
    for (int n = 0; n < M * N; n++) ta[n*DW +: DW] = 8'(n % 16);
    for (int n = 0; n < N * P; n++) tb[n*DW +: DW] = 8'((n + 1) % 16);
    run_mm("t1", ta, tb);
    chk_eq("t1_c00", 64'(result_c[DW-1:0]), 64'h9C);

    // 2: identity times B
    for (int i = 0; i < M; i++)
      for (int k = 0; k < N; k++) ta[(i*N+k)*DW +: DW] = (i == k) ? 8'd1 : 8'd0;
    for (int n = 0; n < N * P; n++) tb[n*DW +: DW] = 8'(n);
    run_mm("t2", ta, tb);
    check_c("t2_eqb", tb);

    // 3: all -1 times all 1
    for (int n = 0; n < M * N; n++) ta[n*DW +: DW] = 8'hFF;
    for (int n = 0; n < N * P; n++) tb[n*DW +: DW] = 8'h01;
    for (int n = 0; n < M * P; n++) tc[n*DW +: DW] = 8'hF8;
    run_mm("t3", ta, tb);
    check_c("t3_const", tc);

    // 4: wrap without saturation
    for (int n = 0; n < M * N; n++) ta[n*DW +: DW] = 8'h7F;
    for (int n = 0; n < N * P; n++) tb[n*DW +: DW] = 8'h7F;
    for (int n = 0; n < M * P; n++) tc[n*DW +: DW] = 8'h08;
    run_mm("t4", ta, tb);
    check_c("t4_wrap", tc);

    // 5: reset in the middle of COMPUTE
    launch("t5", rnd_a(), rnd_b());
    repeat (11) @(posedge clk);
    @(negedge clk);
    chk_eq("t5_busy_done", 64'(done), 64'(0));
    chk_eq("t5_prev_result", 64'(|result_c), 64'(1));
    rst = 1'b0;
    #1;
    chk_eq("t5_rst_done", 64'(done), 64'(0));
    chk_eq("t5_rst_result", 64'(|result_c), 64'(0));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    run_mm("t5_after", rnd_a(), rnd_b());

    // 6: start during COMPUTE is ignored, start in DONE reruns
    ta = rnd_a();
    tb = rnd_b();
    tc = ref_mm(ta, tb);
    launch("t6", ta, tb);
    repeat (5) @(posedge clk);
    @(negedge clk);
    start    = 1'b1;
    matrix_a = rnd_a();
    matrix_b = rnd_b();
    @(posedge clk);
    #1;
    start = 1'b0;
    chk_eq("t6_ignored", 64'(done), 64'(0));
    wait_done("t6", 6);
    check_c("t6", tc);
    repeat (4) @(posedge clk);
    #1;
    chk_eq("t6_hold_done", 64'(done), 64'(1));
    check_c("t6_hold", tc);
    run_mm("t6_rerun", rnd_a(), rnd_b());

    // random operands
    for (int r = 0; r < 4; r++) run_mm($sformatf("rnd%0d", r), rnd_a(), rnd_b());

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
